// File: rtl/bram_rd_arbiter.sv
// Purpose : round-robin arbiter sharing one BRAM read-controller bus among NUM_REQ requesters.
// Latency : request trig to o_bram_trig/o_bram_addr 1 cycle; done/data forwarded combinationally.
// Backpressure: one transaction in flight; losers keep trig high until granted; the owner must drop trig before re-arbitration.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_req_trig / i_req_addr    per-requester level trig and address slice k = [k*ADDR_W +: ADDR_W]
//   o_req_done / o_req_data    done pulse to the granted requester, read data broadcast to all
//   o_bram_addr / o_bram_trig  registered request towards the BRAM read controller
//   i_bram_data / i_bram_done  response from the BRAM read controller
//   o_grant / o_busy           one-hot owner (0 when idle), busy in BUSY or RELEASE
module bram_rd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_trig,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]        o_req_done,
    output logic [DATA_W-1:0]         o_req_data,
    output logic [ADDR_W-1:0]         o_bram_addr,
    output logic                      o_bram_trig,
    input  logic [DATA_W-1:0]         i_bram_data,
    input  logic                      i_bram_done,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_busy
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] ptr_after_owner;
    logic             found;
    int               idx;

    // Winner = first active trig scanning from ptr upwards, wrapping at NUM_REQ.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx  = (int'(ptr) + i) % NUM_REQ;
            cand = idx[IDX_W-1:0];
            if (!found && i_req_trig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign ptr_after_owner = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

    // Next state. RELEASE waits for the owner to drop its trig so a trig that is
    // still high from the finished transaction is never granted a second time.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (|i_req_trig)         state_nxt = ST_BUSY;
            ST_BUSY:    if (i_bram_done)         state_nxt = ST_RELEASE;
            ST_RELEASE: if (!i_req_trig[owner])  state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr         <= '0;
            owner       <= '0;
            o_bram_trig <= 1'b0;
            o_bram_addr <= '0;
            o_grant     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|i_req_trig) begin
                        owner       <= win;
                        o_grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                        o_bram_addr <= i_req_addr[win*ADDR_W +: ADDR_W];
                        o_bram_trig <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    // Owner dropping trig here is not an abort: the bus stays held
                    // until the controller answers.
                    if (i_bram_done) begin
                        o_bram_trig <= 1'b0;
                        ptr         <= ptr_after_owner;
                    end
                end
                ST_RELEASE: begin
                    if (!i_req_trig[owner]) begin
                        o_grant <= '0;
                    end
                end
                default: begin
                    o_bram_trig <= 1'b0;
                    o_grant     <= '0;
                end
            endcase
        end
    end

    // Done goes only to the owner and only while a transaction is in flight;
    // stray controller dones in IDLE/RELEASE are dropped.
    assign o_req_done = (state == ST_BUSY && i_bram_done) ? o_grant : '0;
    assign o_req_data = i_bram_data;
    assign o_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_bram_rd_arbiter.sv
module tb_bram_rd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 32;

    logic                      i_clk = 1'b0;
    logic                      i_rst;
    logic [NUM_REQ-1:0]        i_req_trig;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ-1:0]        o_req_done;
    logic [DATA_W-1:0]         o_req_data;
    logic [ADDR_W-1:0]         o_bram_addr;
    logic                      o_bram_trig;
    logic [DATA_W-1:0]         i_bram_data;
    logic                      i_bram_done;
    logic [NUM_REQ-1:0]        o_grant;
    logic                      o_busy;

    bram_rd_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_trig  (i_req_trig),
        .i_req_addr  (i_req_addr),
        .o_req_done  (o_req_done),
        .o_req_data  (o_req_data),
        .o_bram_addr (o_bram_addr),
        .o_bram_trig (o_bram_trig),
        .i_bram_data (i_bram_data),
        .i_bram_done (i_bram_done),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int                req;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt [NUM_REQ];

    logic              prev_trig  = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [NUM_REQ-1:0] prev_grant = '0;

    function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
        return 32'h5A00_0000 ^ {a, 6'h2B, a};
    endfunction

    // Protocol monitor: one-hot outputs, bus stable while trig is high, done pulse counts.
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_trig = 1'b0;
        end else begin
            n_checks++;
            if (!$onehot0(o_req_done)) begin
                n_fail++;
                $display("FAIL mon_done_onehot0: o_req_done=%b required at most one bit", o_req_done);
            end
            n_checks++;
            if (!$onehot0(o_grant)) begin
                n_fail++;
                $display("FAIL mon_grant_onehot0: o_grant=%b required at most one bit", o_grant);
            end
            if (prev_trig && o_bram_trig) begin
                n_checks++;
                if (o_bram_addr !== prev_addr || o_grant !== prev_grant) begin
                    n_fail++;
                    $display("FAIL mon_bus_stable: addr=%h grant=%b required addr=%h grant=%b",
                             o_bram_addr, o_grant, prev_addr, prev_grant);
                end
            end
            for (int k = 0; k < NUM_REQ; k++)
                if (o_req_done[k] === 1'b1) done_cnt[k]++;
            prev_trig  = o_bram_trig;
            prev_addr  = o_bram_addr;
            prev_grant = o_grant;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [ADDR_W-1:0] a);
        i_req_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic apply_reset();
        i_rst       = 1'b1;
        i_req_trig  = '0;
        i_bram_done = 1'b0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    // BRAM controller model: waits (bounded) for a bus trig, answers after lat cycles.
    task automatic bus_txn(input int lat, input logic [DATA_W-1:0] data,
                           output logic [NUM_REQ-1:0] grant, output logic [ADDR_W-1:0] addr,
                           output logic [NUM_REQ-1:0] done, output logic [DATA_W-1:0] rdata,
                           output bit to);
        to    = 1'b1;
        grant = '0;
        addr  = '0;
        done  = '0;
        rdata = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_bram_trig === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        if (to) return;
        grant = o_grant;
        addr  = o_bram_addr;
        repeat (lat) step();
        i_bram_done = 1'b1;
        i_bram_data = data;
        @(negedge i_clk);
        done  = o_req_done;
        rdata = o_req_data;
        step();
        i_bram_done = 1'b0;
        i_bram_data = '0;
    endtask

    task automatic test_reset();
        i_rst       = 1'b1;
        i_req_trig  = 2'b11;
        i_req_addr  = '0;
        i_bram_done = 1'b0;
        i_bram_data = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_bram_trig !== 1'b0 || o_grant !== 2'b00 || o_busy !== 1'b0 || o_req_done !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_state: trig=%b grant=%b busy=%b done=%b required 0/00/0/00",
                         o_bram_trig, o_grant, o_busy, o_req_done);
            end
        end
        step();
        i_req_trig = '0;
        i_rst      = 1'b0;
        step();
    endtask

    task automatic test_single();
        exp_t e;
        logic [NUM_REQ-1:0] g, d;
        logic [ADDR_W-1:0]  a;
        logic [DATA_W-1:0]  r;
        bit to;
        set_addr(0, 13'h014);
        sb.push_back('{req: 0, addr: 13'h014, data: 32'hDEADBEEF});
        i_req_trig = 2'b01;
        @(negedge i_clk);
        n_checks++;
        if (o_bram_trig !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency_early: o_bram_trig=%b required 0 before the next edge", o_bram_trig);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_bram_trig !== 1'b1 || o_bram_addr !== 13'h014 || o_grant !== 2'b01 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_issue: trig=%b addr=%h grant=%b busy=%b required 1/014/01/1",
                     o_bram_trig, o_bram_addr, o_grant, o_busy);
        end
        e = sb.pop_front();
        bus_txn(2, e.data, g, a, d, r, to);
        n_checks++;
        if (to || g !== (NUM_REQ'(1) << e.req) || a !== e.addr || d !== (NUM_REQ'(1) << e.req) || r !== e.data) begin
            n_fail++;
            $display("FAIL single_txn: to=%0d grant=%b addr=%h done=%b data=%h required grant/done=%b addr=%h data=%h",
                     to, g, a, d, r, NUM_REQ'(1) << e.req, e.addr, e.data);
        end
        i_req_trig = 2'b00;
        step();
        @(negedge i_clk);
        n_checks++;
        if (o_grant !== 2'b00 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: grant=%b busy=%b required 00/0", o_grant, o_busy);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        logic [NUM_REQ-1:0] g, d;
        logic [ADDR_W-1:0]  a;
        logic [DATA_W-1:0]  r;
        bit to;
        apply_reset();
        for (int k = 0; k < NUM_REQ; k++) done_cnt[k] = 0;
        set_addr(0, 13'h100);
        set_addr(1, 13'h200);
        sb.push_back('{req: 0, addr: 13'h100, data: mk_data(13'h100)});
        sb.push_back('{req: 1, addr: 13'h200, data: mk_data(13'h200)});
        i_req_trig = 2'b11;
        for (int t = 0; t < 2; t++) begin
            e = sb.pop_front();
            bus_txn(2, e.data, g, a, d, r, to);
            n_checks++;
            if (to || g !== (NUM_REQ'(1) << e.req) || a !== e.addr || d !== (NUM_REQ'(1) << e.req) || r !== e.data) begin
                n_fail++;
                $display("FAIL contention_txn%0d: to=%0d grant=%b addr=%h done=%b data=%h required grant/done=%b addr=%h data=%h",
                         t, to, g, a, d, r, NUM_REQ'(1) << e.req, e.addr, e.data);
            end
            i_req_trig[e.req] = 1'b0;
        end
        repeat (4) step();
        for (int k = 0; k < NUM_REQ; k++) begin
            n_checks++;
            if (done_cnt[k] !== 1) begin
                n_fail++;
                $display("FAIL contention_done_count%0d: pulses=%0d required 1", k, done_cnt[k]);
            end
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        logic [NUM_REQ-1:0] g, d;
        logic [ADDR_W-1:0]  a;
        logic [DATA_W-1:0]  r;
        bit to;
        set_addr(0, 13'h400);
        set_addr(1, 13'h800);
        sb.push_back('{req: 0, addr: 13'h400, data: mk_data(13'h400)});
        sb.push_back('{req: 1, addr: 13'h800, data: mk_data(13'h800)});
        i_req_trig = 2'b11;
        for (int j = 0; j < 12; j++) begin
            e = sb.pop_front();
            n_checks++;
            if (e.req !== j % 2) begin
                n_fail++;
                $display("FAIL fairness_order%0d: queued req=%0d required %0d", j, e.req, j % 2);
            end
            bus_txn(1 + j % 3, e.data, g, a, d, r, to);
            n_checks++;
            if (to || g !== (NUM_REQ'(1) << e.req) || a !== e.addr || d !== (NUM_REQ'(1) << e.req) || r !== e.data) begin
                n_fail++;
                $display("FAIL fairness_txn%0d: to=%0d grant=%b addr=%h done=%b data=%h required grant/done=%b addr=%h data=%h",
                         j, to, g, a, d, r, NUM_REQ'(1) << e.req, e.addr, e.data);
            end
            i_req_trig[e.req] = 1'b0;
            if (j < 10) begin
                step();
                a = e.addr + 13'd1;
                set_addr(e.req, a);
                sb.push_back('{req: e.req, addr: a, data: mk_data(a)});
                i_req_trig[e.req] = 1'b1;
            end
        end
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL fairness_drain: %0d entries left required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_stale_trig();
        exp_t e;
        logic [NUM_REQ-1:0] g, d;
        logic [ADDR_W-1:0]  a;
        logic [DATA_W-1:0]  r;
        bit to;
        step();
        set_addr(0, 13'h0A5);
        set_addr(1, 13'h15A);
        sb.push_back('{req: 0, addr: 13'h0A5, data: mk_data(13'h0A5)});
        i_req_trig = 2'b01;
        e = sb.pop_front();
        bus_txn(1, e.data, g, a, d, r, to);
        n_checks++;
        if (to || g !== 2'b01 || a !== e.addr || d !== 2'b01 || r !== e.data) begin
            n_fail++;
            $display("FAIL stale_first: to=%0d grant=%b addr=%h done=%b data=%h required 01/%h/01/%h",
                     to, g, a, d, r, e.addr, e.data);
        end
        i_req_trig[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_grant !== 2'b01 || o_bram_trig !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stale_hold%0d: grant=%b trig=%b busy=%b required 01/0/1", c, o_grant, o_bram_trig, o_busy);
            end
            step();
        end
        i_req_trig[0] = 1'b0;
        sb.push_back('{req: 1, addr: 13'h15A, data: mk_data(13'h15A)});
        e = sb.pop_front();
        bus_txn(2, e.data, g, a, d, r, to);
        n_checks++;
        if (to || g !== 2'b10 || a !== e.addr || d !== 2'b10 || r !== e.data) begin
            n_fail++;
            $display("FAIL stale_second: to=%0d grant=%b addr=%h done=%b data=%h required 10/%h/10/%h",
                     to, g, a, d, r, e.addr, e.data);
        end
        i_req_trig[1] = 1'b0;
        step();
        step();
    endtask

    task automatic test_spurious_reset();
        exp_t e;
        logic [NUM_REQ-1:0] g, d;
        logic [ADDR_W-1:0]  a;
        logic [DATA_W-1:0]  r;
        bit to;
        i_bram_done = 1'b1;
        i_bram_data = 32'h1234_5678;
        @(negedge i_clk);
        n_checks++;
        if (o_req_done !== 2'b00 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_idle_done: done=%b busy=%b required 00/0", o_req_done, o_busy);
        end
        step();
        i_bram_done = 1'b0;
        // Serve req0 so the pointer moves to 1 before the mid-transaction reset.
        set_addr(0, 13'h111);
        sb.push_back('{req: 0, addr: 13'h111, data: mk_data(13'h111)});
        i_req_trig = 2'b01;
        e = sb.pop_front();
        bus_txn(1, e.data, g, a, d, r, to);
        n_checks++;
        if (to || g !== 2'b01 || a !== e.addr || d !== 2'b01 || r !== e.data) begin
            n_fail++;
            $display("FAIL midrst_pre: to=%0d grant=%b addr=%h done=%b data=%h required 01/%h/01/%h",
                     to, g, a, d, r, e.addr, e.data);
        end
        i_req_trig = 2'b00;
        step();
        step();
        set_addr(1, 13'h222);
        i_req_trig = 2'b10;
        @(negedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (o_bram_trig !== 1'b1 || o_grant !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_busy: trig=%b grant=%b required 1/10", o_bram_trig, o_grant);
        end
        step();
        i_rst      = 1'b1;
        i_req_trig = 2'b00;
        @(negedge i_clk);
        @(negedge i_clk);
        n_checks++;
        if (o_bram_trig !== 1'b0 || o_grant !== 2'b00 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_drop: trig=%b grant=%b busy=%b required 0/00/0", o_bram_trig, o_grant, o_busy);
        end
        step();
        i_rst       = 1'b0;
        i_bram_done = 1'b1;
        i_bram_data = 32'hBAD0_0BAD;
        @(negedge i_clk);
        n_checks++;
        if (o_req_done !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_late_done: done=%b required 00", o_req_done);
        end
        step();
        i_bram_done = 1'b0;
        // Pointer back at 0: simultaneous requests go to req0 first.
        set_addr(0, 13'h333);
        sb.push_back('{req: 0, addr: 13'h333, data: mk_data(13'h333)});
        sb.push_back('{req: 1, addr: 13'h222, data: mk_data(13'h222)});
        i_req_trig = 2'b11;
        for (int t = 0; t < 2; t++) begin
            e = sb.pop_front();
            bus_txn(2, e.data, g, a, d, r, to);
            n_checks++;
            if (to || g !== (NUM_REQ'(1) << e.req) || a !== e.addr || d !== (NUM_REQ'(1) << e.req) || r !== e.data) begin
                n_fail++;
                $display("FAIL midrst_ptr%0d: to=%0d grant=%b addr=%h done=%b data=%h required grant/done=%b addr=%h data=%h",
                         t, to, g, a, d, r, NUM_REQ'(1) << e.req, e.addr, e.data);
            end
            i_req_trig[e.req] = 1'b0;
        end
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_REQ; k++) done_cnt[k] = 0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stale_trig();
        test_spurious_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
